subneg_mem_arbiter: RTL and testbench

Two-requester arbiter for the single-port word memory of the subneg core. It shares the memory between the core's fetch/execute sequencer and a host loader/debug port, so programs can be loaded and inspected without stopping the core. It sits between both requesters and the memory macro. It owns grant sequencing, round-robin fairness, host burst locking and out-of-range filtering.

---
 rtl/subneg_pkg.sv | 22 ++
 rtl/subneg_rr_pick.sv | 39 +++
 rtl/subneg_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_subneg_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subneg_pkg.sv
// Shared types and sizing constants for the subneg core and its memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package subneg_pkg;

    // Memory geometry shared between the core and the arbiter.
    localparam int SUBNEG_AW    = 5;
    localparam int SUBNEG_DW    = 5;
    localparam int SUBNEG_DEPTH = 22;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/subneg_rr_pick.sv
// Two-way round-robin chooser with host burst lock and a lock-limit override.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
//
// Ports:
//   core_req, host_req : request lines
//   host_lock          : host asks to keep ownership across ties
//   last_owner         : owner of the most recent grant
//   lock_max           : lock budget exhausted, core must win the next tie
//   any_req, winner    : some request present / chosen requester
module subneg_rr_pick
    import subneg_pkg::*;
(
    input  logic   core_req,
    input  logic   host_req,
    input  logic   host_lock,
    input  owner_e last_owner,
    input  logic   lock_max,
    output logic   any_req,
    output owner_e winner
);

    logic hold_host;

    assign any_req = core_req | host_req;

    // The host keeps a tie only if it owned the last grant and its lock budget remains.
    assign hold_host = (last_owner == OWN_HOST) && host_lock && !lock_max;

    always_comb begin
        winner = OWN_CORE;
        if (core_req && host_req) begin
            winner = ((last_owner == OWN_CORE) || hold_host) ? OWN_HOST : OWN_CORE;
        end else if (host_req) begin
            winner = OWN_HOST;
        end
    end

endmodule

// File: rtl/subneg_mem_arbiter.sv
// Core/host arbiter for the single-port subneg word memory (IDLE/GRANT/RESP sequencer).
// Latency: request seen in IDLE -> gnt+mem_en next cycle -> rvalid the cycle after; 1 access per 2 cycles.
// Backpressure: requesters hold req+command until gnt; dropping req before gnt withdraws it.
//
// Ports: core_* and host_* request/grant/response channels, mem_* port to a synchronous
// memory macro (read data one cycle after mem_en), addr_err pulse for addr >= DEPTH,
// contention_cnt statistics. Optional macro SUBNEG_ARB_STATS_EN enables the contention
// counter; without it contention_cnt is tied to zero.
module subneg_mem_arbiter
    import subneg_pkg::*;
#(
    parameter int AW       = SUBNEG_AW,
    parameter int DW       = SUBNEG_DW,
    parameter int DEPTH    = SUBNEG_DEPTH,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          addr_err,
    output logic [7:0]    contention_cnt
);

    localparam int          LCW     = $clog2(LOCK_MAX + 1);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_e         state, state_nxt;
    owner_e         last_owner;  // also the owner of the command currently latched
    owner_e         winner;
    logic           any_req, arb_cycle, lock_max, cmd_ok, resp_rd;
    logic           cmd_we;
    logic [AW-1:0]  cmd_addr;
    logic [DW-1:0]  cmd_wdata;
    logic [LCW-1:0] lock_cnt;
    logic [DW-1:0]  core_rdata_q, host_rdata_q, resp_data;

    // Every non-GRANT cycle is an arbitration cycle, so RESP overlaps the next decision.
    assign arb_cycle = (state != GRANT);
    assign lock_max  = (lock_cnt == LCW'(LOCK_MAX));
    assign cmd_ok    = (32'(cmd_addr) < DEPTH_U);
    assign resp_rd   = (state == RESP) && !cmd_we;
    assign resp_data = cmd_ok ? mem_rdata : '0;

    subneg_rr_pick u_pick (
        .core_req   (core_req),
        .host_req   (host_req),
        .host_lock  (host_lock),
        .last_owner (last_owner),
        .lock_max   (lock_max),
        .any_req    (any_req),
        .winner     (winner)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            GRANT:   state_nxt = RESP;
            default: state_nxt = any_req ? GRANT : IDLE;
        endcase
    end

    // Winner's command is captured at the arbitration edge and replayed in GRANT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWN_HOST;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
        end else if (arb_cycle && any_req) begin
            last_owner <= winner;
            if (winner == OWN_CORE) begin
                cmd_we    <= core_we;
                cmd_addr  <= core_addr;
                cmd_wdata <= core_wdata;
            end else begin
                cmd_we    <= host_we;
                cmd_addr  <= host_addr;
                cmd_wdata <= host_wdata;
            end
        end
    end

    // Locked host grants are only charged while the core is actually waiting, so the
    // count cannot pass LOCK_MAX: at the limit the core wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
        end else if (!host_lock) begin
            lock_cnt <= '0;
        end else if (arb_cycle && any_req) begin
            if (winner == OWN_CORE)  lock_cnt <= '0;
            else if (core_req)       lock_cnt <= lock_cnt + LCW'(1);
        end
    end

    // Read data is held per requester between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else if (resp_rd) begin
            if (last_owner == OWN_CORE) core_rdata_q <= resp_data;
            else                        host_rdata_q <= resp_data;
        end
    end

    // Output decode.
    always_comb begin
        core_gnt    = 1'b0;
        host_gnt    = 1'b0;
        core_rvalid = 1'b0;
        host_rvalid = 1'b0;
        mem_en      = 1'b0;
        addr_err    = 1'b0;
        core_rdata  = core_rdata_q;
        host_rdata  = host_rdata_q;
        case (state)
            GRANT: begin
                core_gnt = (last_owner == OWN_CORE);
                host_gnt = (last_owner == OWN_HOST);
                mem_en   = cmd_ok;
            end
            RESP: begin
                addr_err = !cmd_ok;
                if (!cmd_we) begin
                    if (last_owner == OWN_CORE) begin
                        core_rvalid = 1'b1;
                        core_rdata  = resp_data;
                    end else begin
                        host_rvalid = 1'b1;
                        host_rdata  = resp_data;
                    end
                end
            end
            default: ;
        endcase
    end

    assign mem_we    = mem_en & cmd_we;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

`ifdef SUBNEG_ARB_STATS_EN
    logic [7:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= 8'd0;
        end else if (arb_cycle && core_req && host_req && (stat_q != 8'hFF)) begin
            stat_q <= stat_q + 8'd1;
        end
    end

    assign contention_cnt = stat_q;
`else
    assign contention_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_subneg_mem_arbiter.sv
// Self-checking bench for subneg_mem_arbiter: directed steps plus randomized traffic
// against a transaction-level model (grant timing, fairness/lock rules, memory contents).
// Memory macro is modelled as a synchronous 32-word array.
module tb_subneg_mem_arbiter;
    import subneg_pkg::*;

    localparam int AW = 5, DW = 5, DEPTH = 22, LOCK_MAX = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          addr_err;
    logic [7:0]    contention_cnt;

    always #5 clk = ~clk;

    subneg_mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .addr_err(addr_err), .contention_cnt(contention_cnt)
    );

    // Synchronous memory macro.
    logic [DW-1:0] mem_arr [32];
    always @(posedge clk) begin
        if (mem_en && mem_we)  mem_arr[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem_arr[mem_addr];
    end

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [32];
    owner_e        m_last, p_own;
    int            m_lock, m_cont;
    bit            p_g, p_we, p_ok;
    logic [DW-1:0] p_rd, m_crd, m_hrd;
    bit            s_creq, s_hreq, s_hlock, s_cwe, s_hwe;
    logic [AW-1:0] s_caddr, s_haddr;
    logic [DW-1:0] s_cwd, s_hwd;
    owner_e        glog[$];
    int            rnd_mode = 0, c_keep = 0, h_keep = 0, lock_mode = 0, h_seq = 0, h_next = 0;

    function automatic owner_e decide(bit c, bit h, bit lk, owner_e last, int cnt);
        if (!h) return OWN_CORE;
        if (!c) return OWN_HOST;
        if (last == OWN_HOST && lk && cnt < LOCK_MAX) return OWN_HOST;
        return (last == OWN_HOST) ? OWN_CORE : OWN_HOST;
    endfunction

    task automatic model_reset();
        m_last = OWN_HOST; m_lock = 0; m_cont = 0; p_g = 0;
        m_crd = '0; m_hrd = '0; glog.delete();
    endtask

    task automatic sample();
        s_creq = core_req; s_cwe = core_we; s_caddr = core_addr; s_cwd = core_wdata;
        s_hreq = host_req; s_hwe = host_we; s_haddr = host_addr; s_hwd = host_wdata;
        s_hlock = host_lock;
    endtask

    task automatic new_core_cmd();
        core_we = 1'($urandom_range(0, 1)); core_addr = AW'($urandom_range(0, 31)); core_wdata = DW'($urandom);
    endtask

    task automatic new_host_cmd();
        host_we = 1'($urandom_range(0, 1)); host_addr = AW'($urandom_range(0, 31)); host_wdata = DW'($urandom);
    endtask

    // Requesters react to the grant they just observed.
    task automatic drive_next();
        if (core_gnt) begin
            core_req = (rnd_mode != 0) && (c_keep != 0 || $urandom_range(0, 1) == 1);
            if (rnd_mode != 0) new_core_cmd();
        end else if (rnd_mode != 0 && c_keep == 0) begin
            if (core_req && $urandom_range(0, 7) == 0) core_req = 1'b0;
            else if (!core_req && $urandom_range(0, 2) == 0) begin core_req = 1'b1; new_core_cmd(); end
        end
        if (h_seq != 0) begin
            if (host_gnt) h_next++;
            host_req = (h_next < DEPTH); host_we = 1'b1;
            host_addr = AW'(h_next); host_wdata = DW'(h_next);
        end else if (host_gnt) begin
            host_req = (rnd_mode != 0) && (h_keep != 0 || $urandom_range(0, 1) == 1);
            if (rnd_mode != 0) new_host_cmd();
        end else if (rnd_mode != 0 && h_keep == 0) begin
            if (host_req && $urandom_range(0, 7) == 0) host_req = 1'b0;
            else if (!host_req && $urandom_range(0, 2) == 0) begin host_req = 1'b1; new_host_cmd(); end
        end
        if (lock_mode == 2)      host_lock = 1'($urandom_range(0, 1));
        else                     host_lock = (lock_mode == 1);
    endtask

    // One clock: predict, compare, then let the requesters respond.
    task automatic cycle1();
        bit            g, cw, ok;
        owner_e        w;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        int            ec;
        @(posedge clk); #1;
        // A grant follows any non-grant cycle that saw a request.
        g = !p_g && (s_creq || s_hreq);
        w = g ? decide(s_creq, s_hreq, s_hlock, m_last, m_lock) : OWN_CORE;
        if (w == OWN_CORE) begin cw = s_cwe; ca = s_caddr; cd = s_cwd; end
        else               begin cw = s_hwe; ca = s_haddr; cd = s_hwd; end
        ok = (int'(ca) < DEPTH);
        if (!s_hlock)                     m_lock = 0;
        else if (g && w == OWN_CORE)      m_lock = 0;
        else if (g && s_creq)             m_lock++;
        if (!p_g && s_creq && s_hreq && m_cont < 255) m_cont++;
        chk("core_gnt", 32'(g && w == OWN_CORE), 32'(core_gnt));
        chk("host_gnt", 32'(host_gnt), 32'(g && w == OWN_HOST));
        chk("mem_en", 32'(mem_en), 32'(g && ok));
        if (g && ok) begin
            chk("mem_we", 32'(mem_we), 32'(cw));
            chk("mem_addr", 32'(mem_addr), 32'(ca));
            if (cw) chk("mem_wdata", 32'(mem_wdata), 32'(cd));
        end
        chk("core_rvalid", 32'(core_rvalid), 32'(p_g && p_own == OWN_CORE && !p_we));
        chk("host_rvalid", 32'(host_rvalid), 32'(p_g && p_own == OWN_HOST && !p_we));
        chk("addr_err", 32'(addr_err), 32'(p_g && !p_ok));
        if (p_g && !p_we) begin
            if (p_own == OWN_CORE) m_crd = p_rd;
            else                   m_hrd = p_rd;
        end
        chk("core_rdata", 32'(core_rdata), 32'(m_crd));
        chk("host_rdata", 32'(host_rdata), 32'(m_hrd));
`ifdef SUBNEG_ARB_STATS_EN
        ec = m_cont;
`else
        ec = 0;
`endif
        chk("contention_cnt", 32'(contention_cnt), 32'(ec));
        if (g) begin
            m_last = w;
            glog.push_back(w);
            p_rd = ok ? ref_mem[ca] : '0;
            if (cw && ok) ref_mem[ca] = cd;
        end
        p_g = g; p_own = w; p_we = cw; p_ok = ok;
        drive_next();
        sample();
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_gnt"}, 32'({core_gnt, host_gnt}), 0);
        chk({t, "_rvalid"}, 32'({core_rvalid, host_rvalid}), 0);
        chk({t, "_core_rdata"}, 32'(core_rdata), 0);
        chk({t, "_host_rdata"}, 32'(host_rdata), 0);
        chk({t, "_mem_ctl"}, 32'({mem_en, mem_we}), 0);
        chk({t, "_mem_addr"}, 32'(mem_addr), 0);
        chk({t, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({t, "_addr_err"}, 32'(addr_err), 0);
        chk({t, "_contention"}, 32'(contention_cnt), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; core_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        sample();
    endtask

    // Single directed access from an otherwise idle arbiter.
    task automatic access(input owner_e o, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (o == OWN_CORE) begin core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d; end
        else               begin host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; end
        sample();
        cycle1();
        chk("acc_gnt_n1", 32'(o == OWN_CORE ? core_gnt : host_gnt), 1);
        cycle1();
        chk("acc_rvalid_n2", 32'(o == OWN_CORE ? core_rvalid : host_rvalid), 32'(!we));
        cycle1();
    endtask

    logic [DW-1:0] wd;

    initial begin
        for (int i = 0; i < 32; i++) begin
            wd = DW'($urandom);
            mem_arr[i] = wd;
            ref_mem[i] = wd;
        end
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        sample();

        // Host writes 1 to addr 19, core reads it back.
        access(OWN_HOST, 1'b1, AW'(19), DW'(1));
        access(OWN_CORE, 1'b0, AW'(19), '0);
        chk("core_read_19", 32'(core_rdata), 1);

        // Out-of-range host read and write.
        access(OWN_HOST, 1'b0, AW'(19), '0);
        chk("host_read_19", 32'(host_rdata), 1);
        access(OWN_HOST, 1'b0, AW'(25), '0);
        chk("oor_read_data", 32'(host_rdata), 0);
        access(OWN_HOST, 1'b1, AW'(30), DW'(7));
        chk("oor_write_mem30", 32'(mem_arr[30]), 32'(ref_mem[30]));

        // Core write then host read of addr 5 on consecutive grants.
        wd = ref_mem[5] ^ DW'(5'h15);
        glog.delete();
        core_req = 1'b1; core_we = 1'b1; core_addr = AW'(5); core_wdata = wd;
        host_req = 1'b1; host_we = 1'b0; host_addr = AW'(5);
        sample();
        repeat (5) cycle1();
        chk("wr_rd_first_core", 32'(glog[0]), 32'(OWN_CORE));
        chk("wr_rd_host_data", 32'(host_rdata), 32'(wd));

        // Both requesters held from reset, no lock: strict alternation.
        do_reset();
        rnd_mode = 1; c_keep = 1; h_keep = 1; lock_mode = 0;
        core_req = 1'b1; host_req = 1'b1; new_core_cmd(); new_host_cmd();
        sample();
        repeat (20) cycle1();
        chk("alt_count", 32'(glog.size() >= 8), 1);
        for (int i = 0; i < 8; i++)
            chk("alt_order", 32'(glog[i]), 32'((i % 2 == 1) ? OWN_HOST : OWN_CORE));

        // Locked host burst of writes 0..21 while the core waits.
        do_reset();
        rnd_mode = 1; c_keep = 1; h_keep = 0; h_seq = 1; h_next = 0; lock_mode = 1;
        core_req = 1'b1; new_core_cmd();
        host_req = 1'b1; host_we = 1'b1; host_addr = '0; host_wdata = '0; host_lock = 1'b1;
        sample();
        repeat (70) cycle1();
        chk("lock_count", 32'(glog.size() >= 10), 1);
        for (int i = 0; i < 8; i++) chk("lock_host_run", 32'(glog[i]), 32'(OWN_HOST));
        chk("lock_core_turn", 32'(glog[8]), 32'(OWN_CORE));
        chk("lock_host_resume", 32'(glog[9]), 32'(OWN_HOST));
        chk("lock_all_written", 32'(h_next), 32'(DEPTH));

        // Random traffic with withdrawals and random lock.
        h_seq = 0; c_keep = 0; h_keep = 0; lock_mode = 2;
        repeat (400) cycle1();

        // Quiesce, then reset in the middle of a GRANT.
        rnd_mode = 0; lock_mode = 0;
        core_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
        sample();
        repeat (3) cycle1();
        core_req = 1'b1; core_we = 1'b0; core_addr = AW'(3);
        sample();
        cycle1();
        chk("rst_mid_gnt", 32'(core_gnt), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        model_reset();
        @(posedge clk); #1;
        chk("rst_no_rvalid", 32'({core_rvalid, host_rvalid}), 0);
        rst_n = 1'b1;
        rnd_mode = 1; c_keep = 1; h_keep = 1;
        core_req = 1'b1; host_req = 1'b1; new_core_cmd(); new_host_cmd();
        sample();
        repeat (6) cycle1();
        chk("rst_first_tie_core", 32'(glog[0]), 32'(OWN_CORE));

        // Memory image must match every accepted in-range write and nothing else.
        rnd_mode = 0; core_req = 1'b0; host_req = 1'b0;
        sample();
        repeat (4) cycle1();
        for (int i = 0; i < 32; i++)
            chk("mem_final", 32'(mem_arr[i]), 32'(ref_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
